regfile_dumper: RTL

REGFILE_DUMPER -- requirements
Module: regfile_dumper

---
 rtl/regfile_dumper.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/regfile_dumper.sv
// ---------------------------------------------------------------------------
// regfile_dumper
//
// Walks a contiguous (wrapping) range of register-file entries and streams
// each value out over a valid/ready interface. Each word takes two phases:
// READ drives the read address and captures the value, and SEND holds it
// until downstream accepts it. A write snooped in the READ cycle is
// forwarded so the dump never shows a stale value. Register 0 always
// reads as zero.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   dump request, honoured only when idle
//   abort      in   cancel a dump in progress (no done pulse)
//   first_idx  in   first register of the range, sampled with start
//   last_idx   in   last register of the range, sampled with start
//   rd_addr    out  register file read address (0 outside READ)
//   rd_data    in   register file read data, combinational from rd_addr
//   wr_en      in   snooped register file write enable
//   wr_addr    in   snooped register file write address
//   wr_data    in   snooped register file write data
//   out_valid  out  out_data/out_idx/out_last are valid
//   out_ready  in   downstream accepts the current word
//   out_data   out  captured register value
//   out_idx    out  register index of out_data
//   out_last   out  current word is the final word of the dump
//   busy       out  a dump is in progress
//   done       out  one-cycle pulse after the final word is accepted
// ---------------------------------------------------------------------------
module regfile_dumper #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [$clog2(NREG)-1:0] first_idx,
  input  logic [$clog2(NREG)-1:0] last_idx,
  output logic [$clog2(NREG)-1:0] rd_addr,
  input  logic [XLEN-1:0]         rd_data,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [XLEN-1:0]         wr_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [$clog2(NREG)-1:0] out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cur_q, cur_d;
  logic [AW-1:0]   end_q, end_d;
  logic [AW-1:0]   out_idx_q, out_idx_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic            done_q, done_d;
  logic            is_last;

  assign is_last = (cur_q == end_q);

  // NOTE: every signal written here gets a default before the case so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    rd_addr    = '0;
    out_valid  = 1'b0;
    out_last   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = first_idx;
          end_d   = last_idx;
          state_d = READ;
        end
      end

      READ: begin
        rd_addr   = cur_q;
        out_idx_d = cur_q;
        // x0 is hardwired to zero; a same-cycle write would land after our
        // read, so forward it to avoid dumping the old value.
        if (cur_q == '0) begin
          out_data_d = '0;
        end else if (wr_en && (wr_addr == cur_q)) begin
          out_data_d = wr_data;
        end else begin
          out_data_d = rd_data;
        end
        state_d = SEND;
      end

      SEND: begin
        out_valid = 1'b1;
        out_last  = is_last;
        if (out_ready) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Index width is log2(NREG), so the increment wraps mod NREG.
            cur_d   = cur_q + AW'(1);
            state_d = READ;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Abort overrides both a fresh start and a completing handshake.
    if (abort) begin
      state_d = IDLE;
      cur_d   = cur_q;
      end_d   = end_q;
      done_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, because the interface
      // requires out_data/out_idx to read 0 after reset, not just the FSM.
      state_q    <= IDLE;
      cur_q      <= '0;
      end_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
    end
  end

  assign out_data = out_data_q;
  assign out_idx  = out_idx_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule
